// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - walks the input-vector region, applies each vector to the DUT, writes responses back.
// Optional feature: SEQ_STEP_EN adds the step input; NEXT then waits for a step pulse.
module gate_test_sequencer #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] input_start_address,
   input  logic [15:0] input_end_address,
   input  logic [15:0] dut_start_address,
   output logic        mem_cmd_valid,
   output logic [7:0]  mem_cmd,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rdata_valid,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  dut_in,
   input  logic [7:0]  dut_out,
`ifdef SEQ_STEP_EN
   input  logic        step,
`endif
   output logic        busy,
   output logic        done,
   output logic        range_err,
   output logic [15:0] dut_end_address
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, APPLY, SETTLE, WR_REQ, NEXT, FINISH
   } state_t;

   state_t      state, state_nx;
   logic [15:0] rd_ptr, end_ptr, wr_ptr;
   logic [7:0]  result;
   logic [7:0]  settle_cnt;
   logic        advance;
   logic        range_bad;

`ifdef SEQ_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   assign range_bad = (input_end_address < input_start_address);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Command fields are decoded from state alone, so they cannot change while a request waits for mem_ready.
   always_comb begin
      state_nx      = state;
      mem_cmd_valid = 1'b0;
      mem_cmd       = 8'h00;
      mem_addr      = 16'h0000;
      mem_wdata     = 8'h00;
      case (state)
         IDLE:    if (start && !range_bad) state_nx = RD_REQ;
         RD_REQ: begin
            mem_cmd_valid = 1'b1;
            mem_addr      = rd_ptr;
            if (mem_ready) state_nx = RD_WAIT;
         end
         RD_WAIT: if (mem_rdata_valid) state_nx = APPLY;
         APPLY:   state_nx = SETTLE;
         SETTLE:  if (settle_cnt == 8'd0) state_nx = WR_REQ;
         WR_REQ: begin
            mem_cmd_valid = 1'b1;
            mem_cmd       = 8'h01;
            mem_addr      = wr_ptr;
            mem_wdata     = result;
            if (mem_ready) state_nx = NEXT;
         end
         NEXT:    if (advance) state_nx = (rd_ptr == end_ptr) ? FINISH : RD_REQ;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr          <= 16'h0000;
         end_ptr         <= 16'h0000;
         wr_ptr          <= 16'h0000;
         result          <= 8'h00;
         settle_cnt      <= 8'h00;
         dut_in          <= 8'h00;
         busy            <= 1'b0;
         done            <= 1'b0;
         range_err       <= 1'b0;
         dut_end_address <= 16'h0000;
      end else begin
         done      <= 1'b0;
         range_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (range_bad) begin
                     range_err <= 1'b1;
                  end else begin
                     rd_ptr  <= input_start_address;
                     end_ptr <= input_end_address;
                     wr_ptr  <= dut_start_address;
                     busy    <= 1'b1;
                  end
               end
            end
            RD_WAIT: if (mem_rdata_valid) dut_in <= mem_rdata;
            APPLY:   settle_cnt <= 8'(SETTLE_CYCLES - 1);
            SETTLE: begin
               if (settle_cnt == 8'd0) result <= dut_out;
               else                    settle_cnt <= settle_cnt - 8'd1;
            end
            // Termination is by compare, so a range ending at FFFF never wraps rd_ptr.
            NEXT: begin
               if (advance) begin
                  if (rd_ptr == end_ptr) begin
                     dut_end_address <= wr_ptr;
                     done            <= 1'b1;
                     busy            <= 1'b0;
                  end else begin
                     rd_ptr <= rd_ptr + 16'd1;
                     wr_ptr <= wr_ptr + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - directed bench for gate_test_sequencer with a behavioural memory and inverting DUT.
module tb_gate_test_sequencer;
   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] input_start_address = 16'h0;
   logic [15:0] input_end_address = 16'h0;
   logic [15:0] dut_start_address = 16'h0;
   logic        mem_cmd_valid;
   logic [7:0]  mem_cmd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ready = 1'b0;
   logic        mem_rdata_valid = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;
   logic [7:0]  dut_in;
   logic [7:0]  dut_out;
   logic        step = 1'b1;
   logic        busy, done, range_err;
   logic [15:0] dut_end_address;

   gate_test_sequencer #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .input_start_address(input_start_address),
      .input_end_address(input_end_address),
      .dut_start_address(dut_start_address),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
      .dut_in(dut_in), .dut_out(dut_out),
`ifdef SEQ_STEP_EN
      .step(step),
`endif
      .busy(busy), .done(done), .range_err(range_err),
      .dut_end_address(dut_end_address)
   );

   always #5 clk = ~clk;
   assign dut_out = ~dut_in;

   logic [7:0]  mem [0:65535];
   logic [15:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   logic [15:0] rd_addr[$];
   int          ready_delay = 0;
   int          wait_n = 0;
   int          unstable = 0;
   int          done_cnt = 0;
   int          valid_cnt = 0;
   logic        holding = 1'b0;
   logic [31:0] held;
   logic        pend = 1'b0;
   logic [7:0]  pend_data = 8'h00;
   int          n_checks = 0;
   int          n_pass = 0;

   // Memory responder: decides mem_ready on the falling edge; a granted command is accepted on the next rising edge.
   always @(negedge clk) begin
      mem_rdata_valid = pend;
      mem_rdata       = pend_data;
      pend            = 1'b0;
      if (done) done_cnt++;
      if (mem_cmd_valid) valid_cnt++;
      if (!rst_n) begin
         mem_ready = 1'b0;
         wait_n    = 0;
         holding   = 1'b0;
      end else if (mem_cmd_valid) begin
         if (holding) begin
            if ({mem_cmd, mem_addr, mem_wdata} != held) unstable++;
         end else begin
            held    = {mem_cmd, mem_addr, mem_wdata};
            holding = 1'b1;
         end
         if (wait_n < ready_delay) begin
            mem_ready = 1'b0;
            wait_n++;
         end else begin
            mem_ready = 1'b1;
            wait_n    = 0;
            holding   = 1'b0;
            if (mem_cmd == 8'h00) begin
               pend      = 1'b1;
               pend_data = mem[mem_addr];
               rd_addr.push_back(mem_addr);
            end else begin
               wr_addr.push_back(mem_addr);
               wr_data.push_back(mem_wdata);
            end
         end
      end else begin
         mem_ready = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      rd_addr.delete();
      done_cnt  = 0;
      valid_cnt = 0;
      unstable  = 0;
   endtask

   task automatic pulse_start(input logic [15:0] s, input logic [15:0] e, input logic [15:0] d);
      @(negedge clk);
      input_start_address = s;
      input_end_address   = e;
      dut_start_address   = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_pass(input string tag, input logic [15:0] s, input logic [15:0] e,
                           input logic [15:0] d, output int cycles);
      clear_log();
      pulse_start(s, e, d);
      cycles = 1;
      check({tag, "_busy_after_start"}, busy, 1'b1);
      while (!done && cycles < 2000) begin
         @(negedge clk);
         cycles++;
      end
      check({tag, "_busy_with_done"}, busy, 1'b0);
   endtask

   task automatic check_pass_a(input string tag);
      logic [15:0] ea [3];
      logic [7:0]  ed [3];
      ea = '{16'h0100, 16'h0101, 16'h0102};
      ed = '{8'h5A, 8'hC3, 8'h00};
      check({tag, "_nwrites"}, wr_addr.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_waddr%0d", tag, i), (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx, ea[i]);
         check($sformatf("%s_wdata%0d", tag, i), (i < wr_data.size()) ? wr_data[i] : 8'hxx, ed[i]);
      end
      check({tag, "_first_read"}, (rd_addr.size() > 0) ? rd_addr[0] : 16'hxxxx, 16'h0010);
      check({tag, "_dut_end"}, dut_end_address, 16'h0102);
      repeat (3) @(negedge clk);
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_unstable"}, unstable, 0);
      check({tag, "_dut_in_held"}, dut_in, 8'hFF);
   endtask

   initial begin
      int cyc;
      mem[16'h0010] = 8'hA5;
      mem[16'h0011] = 8'h3C;
      mem[16'h0012] = 8'hFF;
      mem[16'hFFFF] = 8'h12;

      repeat (3) @(negedge clk);
      check("rst_mem", {mem_cmd_valid, mem_cmd, mem_addr, mem_wdata}, 0);
      check("rst_status", {busy, done, range_err, dut_in}, 0);
      check("rst_dut_end", dut_end_address, 16'h0000);
      rst_n = 1'b1;

      run_pass("zw", 16'h0010, 16'h0012, 16'h0100, cyc);
      check("zw_cycles", cyc, 3 * (S + 5) + 1);
      check_pass_a("zw");

      clear_log();
      pulse_start(16'h0020, 16'h001F, 16'h0000);
      check("rerr_pulse", range_err, 1'b1);
      check("rerr_busy", busy, 1'b0);
      @(negedge clk);
      check("rerr_one_cycle", range_err, 1'b0);
      repeat (5) @(negedge clk);
      check("rerr_no_cmd", valid_cnt, 0);

      ready_delay = 5;
      run_pass("ws", 16'h0010, 16'h0012, 16'h0100, cyc);
      check_pass_a("ws");
      ready_delay = 0;

      clear_log();
      pulse_start(16'h0010, 16'h0012, 16'h0100);
      repeat (13) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstmid_mem", {mem_cmd_valid, mem_cmd, mem_addr, mem_wdata}, 0);
      check("rstmid_status", {busy, done, range_err, dut_in}, 0);
      check("rstmid_writes", wr_addr.size(), 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_pass("rerun", 16'h0010, 16'h0012, 16'h0100, cyc);
      check_pass_a("rerun");

      run_pass("top", 16'hFFFF, 16'hFFFF, 16'hFFFF, cyc);
      check("top_cycles", cyc, S + 6);
      repeat (20) @(negedge clk);
      check("top_nreads", rd_addr.size(), 1);
      check("top_nwrites", wr_addr.size(), 1);
      check("top_write", (wr_addr.size() > 0) ? {wr_addr[0], wr_data[0]} : 24'hxxxxxx, {16'hFFFF, 8'hED});
      check("top_dut_end", dut_end_address, 16'hFFFF);

`ifdef SEQ_STEP_EN
      clear_log();
      step = 1'b0;
      pulse_start(16'h0010, 16'h0012, 16'h0100);
      cyc = 0;
      while (wr_addr.size() < 1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      repeat (20) @(negedge clk);
      check("step_no_read", rd_addr.size(), 1);
      check("step_idle_bus", mem_cmd_valid, 1'b0);
      step = 1'b1;
      @(negedge clk);
      check("step_read_next", {mem_cmd_valid, mem_cmd, mem_addr}, {1'b1, 8'h00, 16'h0011});
      cyc = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check_pass_a("step");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Sequences one full test pass of the mini gate tester. Walks the stored input-vector region in memory, issues a read (command 8'h00) per vector, drives the byte onto the DUT inputs, waits a settle interval, and writes the sampled DUT response back to the result region (command 8'h01). Sits between the host-loaded memory/processor interface and the DUT pins, and owns all address generation for a test run.

## Interface
- SETTLE_CYCLES, 4: cycles the DUT input is held stable before `dut_out` is sampled (1..255).
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a pass when idle
- input_start_address  in  16  first input-vector address (inclusive)
- input_end_address  in  16  last input-vector address (inclusive)
- dut_start_address  in  16  first result address
- mem_cmd_valid  out  1  memory command request
- mem_cmd  out  8  8'h00 read, 8'h01 write
- mem_addr  out  16  command address
- mem_wdata  out  8  write data (valid with write command)
- mem_ready  in  1  memory accepts command this cycle
- mem_rdata_valid  in  1  read data valid, one-cycle pulse
- mem_rdata  in  8  read data
- dut_in  out  8  logic inputs to DUT
- dut_out  in  8  DUT outputs (already synchronised externally)
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass completion
- range_err  out  1  one-cycle pulse: start rejected, end < start
- dut_end_address  out  16  last result address written, valid when done pulses
- step  in  1  only with SEQ_STEP_EN: advance to next vector

## Operation
- States: IDLE, RD_REQ, RD_WAIT, APPLY, SETTLE, WR_REQ, NEXT, FINISH.
- IDLE: on `start`, if input_end_address < input_start_address pulse range_err, stay IDLE; else latch all three addresses into rd_ptr/end/wr_ptr, set busy, go RD_REQ.
- RD_REQ: mem_cmd_valid=1, mem_cmd=8'h00, mem_addr=rd_ptr; on mem_ready go RD_WAIT.
- RD_WAIT: on mem_rdata_valid capture mem_rdata into dut_in, go APPLY.
- APPLY: one cycle; load settle counter with SETTLE_CYCLES-1, go SETTLE.
- SETTLE: decrement; at 0 capture dut_out into result register, go WR_REQ.
- WR_REQ: mem_cmd_valid=1, mem_cmd=8'h01, mem_addr=wr_ptr, mem_wdata=result; on mem_ready go NEXT.
- NEXT: if rd_ptr == end go FINISH; else rd_ptr+1, wr_ptr+1 (both mod 2^16), go RD_REQ.
- FINISH: dut_end_address=wr_ptr, pulse done, clear busy, go IDLE.
- mem_cmd, mem_addr, mem_wdata hold stable while mem_cmd_valid is high and mem_ready low; mem_cmd_valid never drops before acceptance.
- mem_rdata_valid outside RD_WAIT ignored. `start` while busy ignored.
- dut_in holds last vector after pass ends until next pass overwrites it.
- Equal start/end: exactly one vector. Range ending at 16'hFFFF terminates on compare, pointer never wraps to 0; wr_ptr may wrap 16'hFFFF→16'h0000.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, mem_cmd 8'h00, mem_addr 16'h0000, dut_in 8'h00, dut_end_address 16'h0000.
- Reset mid-pass aborts immediately; no pending command completes.
- Per vector with zero-wait memory (mem_ready high, rdata next cycle): RD_REQ 1 + RD_WAIT 1 + APPLY 1 + SETTLE SETTLE_CYCLES + WR_REQ 1 + NEXT 1 = SETTLE_CYCLES+5 cycles.
- dut_in updates the cycle after mem_rdata_valid; dut_out sampled SETTLE_CYCLES+1 cycles later.
- busy high the cycle after start; done pulses one cycle after final NEXT, busy low same cycle as done.

## Configuration
- SEQ_STEP_EN defined: `step` port present; NEXT waits for a `step` pulse before proceeding (to RD_REQ or FINISH); step outside NEXT ignored.
- Undefined: no `step` port; NEXT proceeds in one cycle.

## Test plan
- Range 16'h0010..16'h0012 holding 8'hA5,8'h3C,8'hFF, DUT = bitwise NOT, dut_start 16'h0100, zero-wait mem -> writes 8'h5A@0100, 8'hC3@0101, 8'h00@0102; done once; dut_end_address 16'h0102; total 3*(SETTLE_CYCLES+5)+1 cycles after start.
- start with input_start 16'h0020, end 16'h001F -> range_err one cycle, busy stays 0, no mem_cmd_valid.
- mem_ready held low 5 cycles on each request -> command/address stable throughout, results identical to zero-wait run.
- Assert rst_n low during SETTLE of vector 2 -> all outputs 0 immediately; new start re-runs from input_start.
- Range 16'hFFFF..16'hFFFF, dut_start 16'hFFFF -> one read, one write @FFFF, done, no further reads.
- SEQ_STEP_EN: no step after vector 1 for 20 cycles -> no read issued; step -> read of vector 2 next cycle.
